// File: rtl/mul_tc_16_16_booth_seq.sv
// Sequential radix-4 Booth multiplier (16x16 signed -> 32) that drives an external 32-bit adder.
// Optional EARLY_TERM_EN: leave RUN as soon as the remaining Booth digits of b are all zero.
module mul_tc_16_16_booth_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // RUN   | one Booth digit per cycle, acc accumulates adder sum
    // DONE  | product valid, held until out_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [31:0] acc_q;
    logic [2:0]  i_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [16:0] b_ext;
    logic [3:0]  shamt;
    logic [2:0]  trip;
    logic [17:0] a_x1;
    logic [17:0] a_x2;
    logic [17:0] pp;
    logic [31:0] pp_ext;
    logic [31:0] pp_shift;
    logic        run;
    logic        last_digit;

    assign b_ext = {b_q, 1'b0};
    assign shamt = {i_q, 1'b0};
    assign trip  = b_ext[shamt +: 3];
    assign a_x1  = {{2{a_q[15]}}, a_q};
    assign a_x2  = {a_q[15], a_q, 1'b0};

    // The adder has no carry-in, so negative partial products are negated here.
    always_comb begin
        pp = '0;
        case (trip)
            3'b001, 3'b010: pp = a_x1;
            3'b011:         pp = a_x2;
            3'b100:         pp = ~a_x2 + 18'd1;
            3'b101, 3'b110: pp = ~a_x1 + 18'd1;
            default:        pp = '0;
        endcase
    end

    assign pp_ext   = {{14{pp[17]}}, pp};
    assign pp_shift = pp_ext << shamt;
    assign run      = (state_q == RUN);
    assign add_a    = run ? acc_q : 32'd0;
    assign add_b    = run ? pp_shift : 32'd0;

`ifdef EARLY_TERM_EN
    // Arithmetic shift leaves only b[15:2i+1] plus sign copies; all-equal means all 0s or all 1s.
    logic [15:0] b_rest;
    assign b_rest     = $signed(b_q) >>> (shamt + 4'd1);
    assign last_digit = (&b_rest) || ~(|b_rest);
`else
    assign last_digit = (i_q == 3'd7);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= '0;
                        i_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= add_sum;
                    i_q   <= i_q + 3'd1;
                    if (last_digit) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = acc_q;

endmodule

// File: tb/tb_mul_tc_16_16_booth_seq.sv
// Self-checking bench for mul_tc_16_16_booth_seq; the bench models the external adder.
module tb_mul_tc_16_16_booth_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int accept_cyc = 0;
    logic [31:0] exp_q[$];

`ifdef EARLY_TERM_EN
    localparam int LAT3X5 = 2;
`else
    localparam int LAT3X5 = 8;
`endif

    mul_tc_16_16_booth_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    assign add_sum = add_a + add_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Output side of the scoreboard: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_result");
            else check("product", product, exp_q.pop_front());
        end
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic [31:0] e);
        int n = 0;
        a = ta; b = tb_v; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 60) begin @(negedge clk); n++; end
        if (!in_ready) begin
            fail_now("accept");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk); #1;
            accept_cyc = cyc;
            in_valid = 1'b0;
            a = 16'($urandom); b = 16'($urandom);
        end
    endtask

    task automatic wait_out_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 60);
        if (!out_valid) fail_now("out_valid");
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        if (exp_q.size() != 0) fail_now("drain");
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [31:0] vp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic signed [15:0] ra, rb;
        logic signed [31:0] re;
        logic signed [15:0] corners[5];
        int prev;

        vecs[0] = '{16'sd3,      16'sd5,      32'h0000_000F};
        vecs[1] = '{-16'sd32768, -16'sd32768, 32'h4000_0000};
        vecs[2] = '{-16'sd1,     16'sd32767,  32'hFFFF_8001};
        vecs[3] = '{16'sd7,      -16'sd9,     32'hFFFF_FFC1};
        vecs[4] = '{16'sd0,      -16'sd32768, 32'h0000_0000};
        vecs[5] = '{16'sd1,      -16'sd1,     32'hFFFF_FFFF};
        vecs[6] = '{16'sd32767,  16'sd32767,  32'h3FFF_0001};
        vecs[7] = '{-16'sd32768, 16'sd32767,  32'hC000_8000};
        vecs[8] = '{-16'sd32768, 16'sd1,      32'hFFFF_8000};
        vecs[9] = '{16'sd12345,  -16'sd2,     32'hFFFF_9F8E};
        corners = '{16'sd0, 16'sd1, -16'sd1, 16'sd32767, -16'sd32768};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency of the first vector, then the table back-to-back through the scoreboard.
        out_ready = 1'b1;
        issue(vecs[0].va, vecs[0].vb, vecs[0].vp);
        wait_out_valid();
        check("latency_3x5", 32'(cyc - accept_cyc), 32'(LAT3X5));
        drain();
        for (int k = 1; k < 10; k++) issue(vecs[k].va, vecs[k].vb, vecs[k].vp);
        drain();

        // Backpressure: product held, in_valid pulse ignored.
        out_ready = 1'b0;
        issue(16'sd100, -16'sd3, 32'hFFFF_FED4);
        wait_out_valid();
        for (int j = 0; j < 5; j++) begin
            in_valid = (j == 2);
            a = 16'sd1; b = 16'sd1;
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_product", product, 32'hFFFF_FED4);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (15) @(posedge clk);
        #1;
        check("bp_no_second", 32'(out_valid), 32'd0);

        // Reset during the 4th RUN cycle.
        issue(16'sd5, 16'hAAAA, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_add_a", add_a, 32'd0);
        check("mid_rst_add_b", add_b, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(16'sd7, -16'sd9, 32'hFFFF_FFC1);
        drain();

        // Corner pairs and random sweep against the bench's own product model.
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                ra = corners[i]; rb = corners[j]; re = ra * rb;
                issue(ra, rb, re);
            end
        for (int k = 0; k < 2000; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); re = ra * rb;
            issue(ra, rb, re);
        end
        drain();

        // Back-to-back with in_valid held high.
        prev = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            ra = 16'($urandom); rb = 16'($urandom); re = ra * rb;
            a = ra; b = rb;
            @(negedge clk);
            while (!in_ready && n < 60) begin @(negedge clk); n++; end
            if (!in_ready) begin
                fail_now("b2b_accept");
                break;
            end
            exp_q.push_back(re);
            @(posedge clk); #1;
`ifndef EARLY_TERM_EN
            if (k > 0) check("b2b_interval", 32'(cyc - prev), 32'd10);
`endif
            prev = cyc;
        end
        in_valid = 1'b0;
        drain();
        repeat (15) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
